// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT stage datapath and control.
package fft_pkg;

    localparam int unsigned DATA_W  = 24;
    localparam int unsigned TW_W    = 16;
    localparam int unsigned BF_LAT  = 3;
    localparam int unsigned TW_FRAC = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly addressing for one DIT stage: maps butterfly index k and stage s
// to the operand pair (p, q) and the twiddle ROM index.
module fft_addr_gen import fft_pkg::*; #(
    parameter int unsigned N_LOG2 = 3,
    parameter int unsigned TWI_W  = (N_LOG2 > 1) ? N_LOG2 - 1 : 1
) (
    input  logic [N_LOG2-1:0] i_k,
    input  logic [3:0]        i_s,
    output logic [N_LOG2-1:0] o_p,
    output logic [N_LOG2-1:0] o_q,
    output logic [TWI_W-1:0]  o_tw_idx
);

    logic [N_LOG2-1:0] w_span;
    logic [N_LOG2-1:0] w_j;
    logic [N_LOG2-1:0] w_g;
    logic [N_LOG2-1:0] w_tw_full;
    logic [4:0]        w_tw_sh;

    always_comb begin
        w_span = N_LOG2'(1) << i_s;
        w_j    = i_k & (w_span - N_LOG2'(1));
        w_g    = i_k >> i_s;
        o_p    = (w_g << ({1'b0, i_s} + 5'd1)) | w_j;
        o_q    = o_p | w_span;
        // Out-of-range stages never issue, but keep the shift well defined.
        w_tw_sh = 5'(N_LOG2 - 1) - {1'b0, i_s};
        if ({1'b0, i_s} < 5'(N_LOG2)) begin
            w_tw_full = w_j << w_tw_sh;
        end else begin
            w_tw_full = '0;
        end
        o_tw_idx = w_tw_full[TWI_W-1:0];
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one in-place radix-2 DIT FFT stage: issues RAM/ROM reads, feeds
// the pipelined butterfly and writes results back to the addresses they came from.
module fft_stage_ctrl import fft_pkg::*; #(
    parameter int unsigned N_LOG2 = 3,
    parameter int unsigned BF_LAT = fft_pkg::BF_LAT,
    localparam int unsigned TWI_W = (N_LOG2 > 1) ? N_LOG2 - 1 : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [3:0]               i_stage,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_rd_en,
    output logic [N_LOG2-1:0]        o_rd_addr_p,
    output logic [N_LOG2-1:0]        o_rd_addr_q,
    input  logic signed [DATA_W-1:0] i_rd_xp_real,
    input  logic signed [DATA_W-1:0] i_rd_xp_imag,
    input  logic signed [DATA_W-1:0] i_rd_xq_real,
    input  logic signed [DATA_W-1:0] i_rd_xq_imag,
    output logic [TWI_W-1:0]         o_tw_idx,
    input  logic signed [TW_W-1:0]   i_tw_real,
    input  logic signed [TW_W-1:0]   i_tw_imag,
    output logic                     o_bf_en,
    output logic signed [DATA_W-1:0] o_bf_xp_real,
    output logic signed [DATA_W-1:0] o_bf_xp_imag,
    output logic signed [DATA_W-1:0] o_bf_xq_real,
    output logic signed [DATA_W-1:0] o_bf_xq_imag,
    output logic signed [TW_W-1:0]   o_bf_factor_real,
    output logic signed [TW_W-1:0]   o_bf_factor_imag,
    input  logic                     i_bf_valid,
    input  logic signed [DATA_W-1:0] i_bf_yp_real,
    input  logic signed [DATA_W-1:0] i_bf_yp_imag,
    input  logic signed [DATA_W-1:0] i_bf_yq_real,
    input  logic signed [DATA_W-1:0] i_bf_yq_imag,
    output logic                     o_wr_en,
    output logic [N_LOG2-1:0]        o_wr_addr_p,
    output logic [N_LOG2-1:0]        o_wr_addr_q,
    output logic signed [DATA_W-1:0] o_wr_yp_real,
    output logic signed [DATA_W-1:0] o_wr_yp_imag,
    output logic signed [DATA_W-1:0] o_wr_yq_real,
    output logic signed [DATA_W-1:0] o_wr_yq_imag
);

    localparam int unsigned       HALF      = 1 << (N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] K_LAST    = N_LOG2'(HALF - 1);
    localparam logic [N_LOG2-1:0] ONE       = N_LOG2'(1);
    localparam logic [3:0]        STAGE_LIM = 4'(N_LOG2);

    fft_state_e        r_state;
    fft_state_e        w_state_d;
    logic [N_LOG2-1:0] r_k;
    logic [N_LOG2-1:0] w_k_d;
    logic [3:0]        r_s;
    logic [3:0]        w_s_d;
    logic              r_rd_en;
    logic              w_rd_en_d;
    logic              r_bf_en;
    logic [N_LOG2-1:0] r_rd_addr_p;
    logic [N_LOG2-1:0] r_rd_addr_q;
    logic [TWI_W-1:0]  r_tw_idx;
    logic [N_LOG2-1:0] w_p;
    logic [N_LOG2-1:0] w_q;
    logic [TWI_W-1:0]  w_tw;
    logic [N_LOG2-1:0] r_outst;
    logic [N_LOG2-1:0] w_outst_d;
    logic [N_LOG2-1:0] r_dl_p [BF_LAT+1];
    logic [N_LOG2-1:0] r_dl_q [BF_LAT+1];
    logic              w_busy;
    logic              w_wr_en;
    cplx_t             w_xp;
    cplx_t             w_xq;
    cplx_t             w_yp;
    cplx_t             w_yq;

    assign w_busy  = (r_state != ST_IDLE);
    // Results arriving outside a stage (e.g. after a mid-run reset) are dropped.
    assign w_wr_en = i_bf_valid & w_busy;

    always_comb begin
        w_outst_d = r_outst;
        if (r_rd_en && !w_wr_en) begin
            w_outst_d = r_outst + ONE;
        end else if (!r_rd_en && w_wr_en) begin
            w_outst_d = r_outst - ONE;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_s_d     = r_s;
        w_rd_en_d = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_s_d = i_stage;
                    w_k_d = '0;
                    if (i_stage >= STAGE_LIM) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_ISSUE;
                        w_rd_en_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (r_k == K_LAST) begin
                    w_state_d = ST_DRAIN;
                end else begin
                    w_k_d     = r_k + ONE;
                    w_rd_en_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_outst_d == '0) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Addresses are computed for the butterfly issued next cycle so they register
    // alongside rd_en.
    fft_addr_gen #(
        .N_LOG2 (N_LOG2),
        .TWI_W  (TWI_W)
    ) u_addr_gen (
        .i_k      (w_k_d),
        .i_s      (w_s_d),
        .o_p      (w_p),
        .o_q      (w_q),
        .o_tw_idx (w_tw)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_s         <= '0;
            r_rd_en     <= 1'b0;
            r_bf_en     <= 1'b0;
            r_rd_addr_p <= '0;
            r_rd_addr_q <= '0;
            r_tw_idx    <= '0;
            r_outst     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_k         <= w_k_d;
            r_s         <= w_s_d;
            r_rd_en     <= w_rd_en_d;
            r_bf_en     <= r_rd_en;
            r_rd_addr_p <= w_rd_en_d ? w_p : '0;
            r_rd_addr_q <= w_rd_en_d ? w_q : '0;
            r_tw_idx    <= w_rd_en_d ? w_tw : '0;
            r_outst     <= w_outst_d;
        end
    end

    // Tap BF_LAT lines up with bf_valid: one cycle of RAM latency plus BF_LAT.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int unsigned i = 0; i <= BF_LAT; i++) begin
                r_dl_p[i] <= '0;
                r_dl_q[i] <= '0;
            end
        end else begin
            r_dl_p[0] <= r_rd_addr_p;
            r_dl_q[0] <= r_rd_addr_q;
            for (int unsigned i = 1; i <= BF_LAT; i++) begin
                r_dl_p[i] <= r_dl_p[i-1];
                r_dl_q[i] <= r_dl_q[i-1];
            end
        end
    end

    always_comb begin
        w_xp = '{re: i_rd_xp_real, im: i_rd_xp_imag};
        w_xq = '{re: i_rd_xq_real, im: i_rd_xq_imag};
        w_yp = '{re: i_bf_yp_real, im: i_bf_yp_imag};
        w_yq = '{re: i_bf_yq_real, im: i_bf_yq_imag};
        if (!r_bf_en) begin
            w_xp = '0;
            w_xq = '0;
        end
        if (!w_wr_en) begin
            w_yp = '0;
            w_yq = '0;
        end
    end

    assign o_busy           = w_busy;
    assign o_done           = (r_state == ST_DONE);
    assign o_rd_en          = r_rd_en;
    assign o_rd_addr_p      = r_rd_addr_p;
    assign o_rd_addr_q      = r_rd_addr_q;
    assign o_tw_idx         = r_tw_idx;
    assign o_bf_en          = r_bf_en;
    assign o_bf_xp_real     = w_xp.re;
    assign o_bf_xp_imag     = w_xp.im;
    assign o_bf_xq_real     = w_xq.re;
    assign o_bf_xq_imag     = w_xq.im;
    assign o_bf_factor_real = r_bf_en ? i_tw_real : '0;
    assign o_bf_factor_imag = r_bf_en ? i_tw_imag : '0;
    assign o_wr_en          = w_wr_en;
    assign o_wr_addr_p      = r_dl_p[BF_LAT];
    assign o_wr_addr_q      = r_dl_q[BF_LAT];
    assign o_wr_yp_real     = w_yp.re;
    assign o_wr_yp_imag     = w_yp.im;
    assign o_wr_yq_real     = w_yq.re;
    assign o_wr_yq_imag     = w_yq.im;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (N=8) with RAM, twiddle ROM and butterfly models.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    localparam int N_LOG2 = 3;
    localparam int N      = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              start;
    logic [3:0]        stage;
    logic              busy, done, rd_en, bf_en, bf_valid, wr_en;
    logic [2:0]        rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
    logic [1:0]        tw_idx;
    logic signed [23:0] rxp_re, rxp_im, rxq_re, rxq_im;
    logic signed [15:0] tw_re, tw_im;
    logic signed [23:0] bxp_re, bxp_im, bxq_re, bxq_im;
    logic signed [15:0] bf_w_re, bf_w_im;
    logic signed [23:0] byp_re, byp_im, byq_re, byq_im;
    logic signed [23:0] wyp_re, wyp_im, wyq_re, wyq_im;

    fft_stage_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(3)) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_start          (start),
        .i_stage          (stage),
        .o_busy           (busy),
        .o_done           (done),
        .o_rd_en          (rd_en),
        .o_rd_addr_p      (rd_addr_p),
        .o_rd_addr_q      (rd_addr_q),
        .i_rd_xp_real     (rxp_re),
        .i_rd_xp_imag     (rxp_im),
        .i_rd_xq_real     (rxq_re),
        .i_rd_xq_imag     (rxq_im),
        .o_tw_idx         (tw_idx),
        .i_tw_real        (tw_re),
        .i_tw_imag        (tw_im),
        .o_bf_en          (bf_en),
        .o_bf_xp_real     (bxp_re),
        .o_bf_xp_imag     (bxp_im),
        .o_bf_xq_real     (bxq_re),
        .o_bf_xq_imag     (bxq_im),
        .o_bf_factor_real (bf_w_re),
        .o_bf_factor_imag (bf_w_im),
        .i_bf_valid       (bf_valid),
        .i_bf_yp_real     (byp_re),
        .i_bf_yp_imag     (byp_im),
        .i_bf_yq_real     (byq_re),
        .i_bf_yq_imag     (byq_im),
        .o_wr_en          (wr_en),
        .o_wr_addr_p      (wr_addr_p),
        .o_wr_addr_q      (wr_addr_q),
        .o_wr_yp_real     (wyp_re),
        .o_wr_yp_imag     (wyp_im),
        .o_wr_yq_real     (wyq_re),
        .o_wr_yq_imag     (wyq_im)
    );

    // Sample RAM and twiddle ROM models (W_8^k, Q2.13).
    logic signed [23:0] mem_re [N];
    logic signed [23:0] mem_im [N];
    logic signed [15:0] rom_re [4] = '{16'sd8192, 16'sd5793, 16'sd0, -16'sd5793};
    logic signed [15:0] rom_im [4] = '{16'sd0, -16'sd5793, -16'sd8192, -16'sd5793};
    logic               init_req;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < N; i++) begin
                mem_re[i] <= (i == 0) ? 24'sd8192 : 24'sd0;
                mem_im[i] <= 24'sd0;
            end
        end else if (wr_en) begin
            mem_re[wr_addr_p] <= wyp_re;
            mem_im[wr_addr_p] <= wyp_im;
            mem_re[wr_addr_q] <= wyq_re;
            mem_im[wr_addr_q] <= wyq_im;
        end
        if (rd_en) begin
            rxp_re <= mem_re[rd_addr_p];
            rxp_im <= mem_im[rd_addr_p];
            rxq_re <= mem_re[rd_addr_q];
            rxq_im <= mem_im[rd_addr_q];
            tw_re  <= rom_re[tw_idx];
            tw_im  <= rom_im[tw_idx];
        end
    end

    function automatic logic [95:0] bfly(input logic signed [23:0] pr, input logic signed [23:0] pi,
                                         input logic signed [23:0] qr, input logic signed [23:0] qi,
                                         input logic signed [15:0] wr, input logic signed [15:0] wi);
        longint tr, ti;
        logic signed [23:0] a, b, c, d;
        tr = (longint'(wr) * longint'(qr) - longint'(wi) * longint'(qi)) >>> 13;
        ti = (longint'(wr) * longint'(qi) + longint'(wi) * longint'(qr)) >>> 13;
        a = 24'(longint'(pr) + tr);
        b = 24'(longint'(pi) + ti);
        c = 24'(longint'(pr) - tr);
        d = 24'(longint'(pi) - ti);
        return {a, b, c, d};
    endfunction

    // Behavioural 3-cycle butterfly; deliberately not reset so stray results can occur.
    logic [95:0] pipe [3];
    logic [2:0]  pv = 3'b000;
    always @(posedge clk) begin
        pv      <= {pv[1:0], bf_en};
        pipe[0] <= bfly(bxp_re, bxp_im, bxq_re, bxq_im, bf_w_re, bf_w_im);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign bf_valid = pv[2];
    assign {byp_re, byp_im, byq_re, byq_im} = pipe[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors, checks;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-run observation log, relative to the start cycle.
    int rd_p [8], rd_q [8], rd_tw [8], rd_c [8];
    int n_rd, n_bf, n_wr, n_done, n_busy;
    int bf_first, wr_first, done_c, busy_first;

    task automatic run(input logic [3:0] s, input int extra_at, input int rst_at, input int ncyc);
        n_rd = 0; n_bf = 0; n_wr = 0; n_done = 0; n_busy = 0;
        bf_first = -1; wr_first = -1; done_c = -1; busy_first = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == extra_at);
            stage = (c == extra_at) ? 4'd2 : s;
            if (c == rst_at) begin
                rstn = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_rd_en", rd_en, 0);
                check("rst_wr_en", wr_en, 0);
                check("rst_other_outputs", |{done, bf_en, rd_addr_p, rd_addr_q, tw_idx, bxp_re,
                      bxp_im, bxq_re, bxq_im, bf_w_re, bf_w_im, wr_addr_p, wr_addr_q, wyp_re,
                      wyp_im, wyq_re, wyq_im}, 0);
            end
            if (c == rst_at + 1) rstn = 1'b1;
            @(negedge clk);
            if (rd_en && n_rd < 8) begin
                rd_p[n_rd] = int'(rd_addr_p);
                rd_q[n_rd] = int'(rd_addr_q);
                rd_tw[n_rd] = int'(tw_idx);
                rd_c[n_rd] = c;
                n_rd++;
            end
            if (bf_en) begin
                if (bf_first < 0) bf_first = c;
                n_bf++;
            end
            if (wr_en) begin
                if (wr_first < 0) wr_first = c;
                n_wr++;
            end
            if (done) begin
                done_c = c;
                n_done++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                n_busy++;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int stage;
        int k;
        int p;
        int q;
        int tw;
    } vec_t;
    vec_t vecs [12];

    initial begin
        errors = 0;
        checks = 0;
        rstn = 1'b0;
        start = 1'b0;
        stage = 4'd0;
        init_req = 1'b1;
        vecs[0]  = '{0, 0, 0, 1, 0};
        vecs[1]  = '{0, 1, 2, 3, 0};
        vecs[2]  = '{0, 2, 4, 5, 0};
        vecs[3]  = '{0, 3, 6, 7, 0};
        vecs[4]  = '{1, 0, 0, 2, 0};
        vecs[5]  = '{1, 1, 1, 3, 2};
        vecs[6]  = '{1, 2, 4, 6, 0};
        vecs[7]  = '{1, 3, 5, 7, 2};
        vecs[8]  = '{2, 0, 0, 4, 0};
        vecs[9]  = '{2, 1, 1, 5, 1};
        vecs[10] = '{2, 2, 2, 6, 2};
        vecs[11] = '{2, 3, 3, 7, 3};
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_wr_en", wr_en, 0);
        init_req = 1'b0;
        rstn = 1'b1;

        // Impulse through stages 0..2 with address/twiddle table checks.
        for (int s = 0; s < 3; s++) begin
            run(4'(s), -1, -1, 14);
            check($sformatf("s%0d_n_rd", s), n_rd, 4);
            check($sformatf("s%0d_bf_first", s), bf_first, 2);
            check($sformatf("s%0d_n_bf", s), n_bf, 4);
            check($sformatf("s%0d_wr_first", s), wr_first, 5);
            check($sformatf("s%0d_n_wr", s), n_wr, 4);
            check($sformatf("s%0d_n_done", s), n_done, 1);
            check($sformatf("s%0d_done_cycle", s), done_c, 9);
            check($sformatf("s%0d_busy_first", s), busy_first, 1);
            check($sformatf("s%0d_n_busy", s), n_busy, 9);
            for (int v = 0; v < 12; v++) begin
                if (vecs[v].stage == s && vecs[v].k < n_rd) begin
                    check($sformatf("s%0d_k%0d_p", s, vecs[v].k), rd_p[vecs[v].k], vecs[v].p);
                    check($sformatf("s%0d_k%0d_q", s, vecs[v].k), rd_q[vecs[v].k], vecs[v].q);
                    check($sformatf("s%0d_k%0d_tw", s, vecs[v].k), rd_tw[vecs[v].k], vecs[v].tw);
                    check($sformatf("s%0d_k%0d_cyc", s, vecs[v].k), rd_c[vecs[v].k], vecs[v].k + 1);
                end
            end
            if (s == 0) begin
                check("after_s0_mem1_re", mem_re[1], 8192);
                check("after_s0_mem1_im", mem_im[1], 0);
            end
        end
        for (int a = 0; a < N; a++) begin
            check($sformatf("final_mem%0d_re", a), mem_re[a], 8192);
            check($sformatf("final_mem%0d_im", a), mem_im[a], 0);
        end

        // Second start in cycle 3 (with a different stage) must be ignored.
        run(4'd0, 3, -1, 14);
        check("busy_start_n_rd", n_rd, 4);
        check("busy_start_n_wr", n_wr, 4);
        check("busy_start_n_done", n_done, 1);
        check("busy_start_done_cycle", done_c, 9);
        check("busy_start_k3_p", rd_p[3], 6);
        check("busy_start_k3_q", rd_q[3], 7);

        // Reset in cycle 6: in-flight results must not be written.
        run(4'd0, -1, 6, 16);
        check("midrst_n_wr", n_wr, 1);
        check("midrst_n_done", n_done, 0);
        check("midrst_n_busy", n_busy, 5);

        // Out-of-range stage: immediate done, no traffic.
        run(4'd5, -1, -1, 8);
        check("bad_stage_n_rd", n_rd, 0);
        check("bad_stage_n_wr", n_wr, 0);
        check("bad_stage_done_cycle", done_c, 1);
        check("bad_stage_n_done", n_done, 1);
        check("bad_stage_n_busy", n_busy, 1);

        // Outstanding count must have been cleared by the mid-run reset.
        run(4'd1, -1, -1, 14);
        check("post_rst_n_rd", n_rd, 4);
        check("post_rst_n_wr", n_wr, 4);
        check("post_rst_done_cycle", done_c, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
